// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter. Takes one stereo pair of 16-bit samples through a
// one-entry holding register and serializes it as a standard I2S frame
// (32 BCLK slots, MSB first, WS leading the MSB by one BCLK).
// BCLK is derived from clk_sys by a divider (CLK_DIV cycles per half-period).
// Optional feature: define I2S_TX_UNDERRUN_CNT_EN to add a saturating 16-bit
// underrun counter output (underrun_cnt).
module i2s_tx #(
    parameter int CLK_DIV = 8
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic        enable,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        i2s_bclk,
    output logic        i2s_ws,
    output logic        i2s_data,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic [15:0] underrun_cnt,
`endif
    output logic        underrun
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [7:0]  div_r;
    logic [4:0]  slot_r;
    logic        bclk_r;
    logic        ws_r;
    logic        data_r;
    logic        underrun_r;
    logic [31:0] frame_r;

    logic [15:0] hold_l_r;
    logic [15:0] hold_r_r;
    logic        full_r;
    logic        ready_r;

    logic [7:0]  div_next_s;
    logic [4:0]  slot_next_s;
    logic        bclk_next_s;
    logic        ws_next_s;
    logic        data_next_s;
    logic        underrun_next_s;
    logic [31:0] frame_next_s;
    logic        frame_load_s;
    logic        out_update_s;
    logic [4:0]  bit_idx_s;

    logic [31:0] frame_src_s;
    logic        take_s;
    logic        consume_s;
    logic        full_next_s;

    // An empty holding register yields a silent frame.
    assign frame_src_s = full_r ? {hold_l_r, hold_r_r} : 32'h0000_0000;
    assign take_s      = in_valid & ready_r;
    assign consume_s   = frame_load_s & full_r;

    // State register.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: enable alone decides between running and idling.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values for divider, BCLK, slot, WS, data and frame.
    always_comb begin
        div_next_s      = div_r;
        bclk_next_s     = bclk_r;
        slot_next_s     = slot_r;
        ws_next_s       = ws_r;
        data_next_s     = data_r;
        frame_next_s    = frame_r;
        underrun_next_s = 1'b0;
        frame_load_s    = 1'b0;
        out_update_s    = 1'b0;
        bit_idx_s       = 5'd0;
        case (state_r)
            ST_IDLE: begin
                div_next_s  = 8'd0;
                bclk_next_s = 1'b0;
                slot_next_s = 5'd0;
                if (enable) begin
                    frame_load_s = 1'b1;
                    out_update_s = 1'b1;
                end else begin
                    ws_next_s   = 1'b0;
                    data_next_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    div_next_s  = 8'd0;
                    bclk_next_s = 1'b0;
                    slot_next_s = 5'd0;
                    ws_next_s   = 1'b0;
                    data_next_s = 1'b0;
                end else if (div_r == DIV_LAST) begin
                    div_next_s  = 8'd0;
                    bclk_next_s = ~bclk_r;
                    if (bclk_r) begin
                        // Falling BCLK edge: move to the next slot.
                        slot_next_s  = slot_r + 5'd1;
                        out_update_s = 1'b1;
                        if (slot_r == 5'd31) begin
                            frame_load_s = 1'b1;
                        end else begin
                            frame_load_s = 1'b0;
                        end
                    end else begin
                        out_update_s = 1'b0;
                    end
                end else begin
                    div_next_s = div_r + 8'd1;
                end
            end
            default: begin
                div_next_s  = 8'd0;
                bclk_next_s = 1'b0;
                slot_next_s = 5'd0;
                ws_next_s   = 1'b0;
                data_next_s = 1'b0;
            end
        endcase

        if (frame_load_s) begin
            frame_next_s    = frame_src_s;
            underrun_next_s = ~full_r;
        end else begin
            frame_next_s    = frame_next_s;
        end

        // Slot s carries frame bit 31-s; WS is high one slot ahead of R.
        bit_idx_s = 5'd31 - slot_next_s;
        if (out_update_s) begin
            data_next_s = frame_next_s[bit_idx_s];
            ws_next_s   = (slot_next_s >= 5'd15) && (slot_next_s <= 5'd30);
        end else begin
            data_next_s = data_next_s;
        end
    end

    // Serializer datapath and output registers.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            div_r      <= 8'd0;
            slot_r     <= 5'd0;
            bclk_r     <= 1'b0;
            ws_r       <= 1'b0;
            data_r     <= 1'b0;
            underrun_r <= 1'b0;
            frame_r    <= 32'h0000_0000;
        end else begin
            div_r      <= div_next_s;
            slot_r     <= slot_next_s;
            bclk_r     <= bclk_next_s;
            ws_r       <= ws_next_s;
            data_r     <= data_next_s;
            underrun_r <= underrun_next_s;
            frame_r    <= frame_next_s;
        end
    end

    // Holding-register occupancy: a consume and a take are mutually exclusive.
    always_comb begin
        full_next_s = full_r;
        if (consume_s) begin
            full_next_s = 1'b0;
        end else if (take_s) begin
            full_next_s = 1'b1;
        end else begin
            full_next_s = full_r;
        end
    end

    // Holding register and registered ready flag.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            hold_l_r <= 16'h0000;
            hold_r_r <= 16'h0000;
            full_r   <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            if (take_s) begin
                hold_l_r <= in_l;
                hold_r_r <= in_r;
            end else begin
                hold_l_r <= hold_l_r;
                hold_r_r <= hold_r_r;
            end
            full_r  <= full_next_s;
            ready_r <= ~full_next_s;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cnt_r;

    // Saturating underrun counter, updated on the same edge the pulse appears.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            cnt_r <= 16'h0000;
        end else if (underrun_next_s && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign underrun_cnt = cnt_r;
`endif

    assign in_ready = ready_r;
    assign i2s_bclk = bclk_r;
    assign i2s_ws   = ws_r;
    assign i2s_data = data_r;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed self-checking bench for i2s_tx with CLK_DIV=4.
// A small I2S receiver samples data/WS on rising BCLK, slot by slot.
module tb_i2s_tx;

    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] in_l = 16'h0000;
    logic [15:0] in_r = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        i2s_bclk;
    logic        i2s_ws;
    logic        i2s_data;
    logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int under_pulses = 0;

    i2s_tx #(.CLK_DIV(4)) dut (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .enable    (enable),
        .in_l      (in_l),
        .in_r      (in_r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i2s_bclk  (i2s_bclk),
        .i2s_ws    (i2s_ws),
        .i2s_data  (i2s_data),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .underrun  (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Cycle counter and underrun high-cycle counter.
    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (underrun) under_pulses <= under_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Wait for the next rising BCLK, sampled 1 time unit after clk_sys edges.
    task automatic wait_rise();
        int n;
        logic ok;
        n = 0;
        while (i2s_bclk === 1'b1 && n < 300) begin tick(); n++; end
        while (i2s_bclk !== 1'b1 && n < 300) begin tick(); n++; end
        ok = (i2s_bclk === 1'b1);
        if (!ok) check("bclk_rise_timeout", {31'd0, ok}, 32'd1);
    endtask

    // Receive one frame: 32 rising edges, slot k -> L[15-k] / R[31-k].
    task automatic capture_frame(output logic [15:0] l, output logic [15:0] r,
                                 output logic ws_ok, output int t0, output int t1);
        logic exp_ws;
        l = 16'h0000; r = 16'h0000; ws_ok = 1'b1; t0 = 0; t1 = 0;
        for (int k = 0; k < 32; k++) begin
            wait_rise();
            if (k == 0) t0 = cyc;
            if (k == 1) t1 = cyc;
            if (k < 16) l[15-k] = i2s_data;
            else        r[31-k] = i2s_data;
            exp_ws = (k >= 15) && (k <= 30);
            if (i2s_ws !== exp_ws) ws_ok = 1'b0;
        end
    endtask

    // Offer the current in_l/in_r until accepted (bounded).
    task automatic push_wait();
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        while (!ok && n < 1000) begin
            @(negedge clk_sys);
            if (in_ready === 1'b1) ok = 1'b1;
            n++;
        end
        if (!ok) check("push_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk_sys);
        #1;
        in_valid = 1'b0;
    endtask

    logic [15:0] rl, rr;
    logic        wsok;
    int          ta, tb, tc, p0;

    initial begin
        // Reset state.
        tick(); tick();
        check("rst_outputs", {27'd0, i2s_bclk, i2s_ws, i2s_data, underrun, in_ready}, 32'd0);
        RESET = 1'b0;
        tick();
        check("rst_ready", in_ready, 1'b1);

        // Basic frame: L=A5F0 R=0F5A.
        p0 = under_pulses;
        in_l = 16'hA5F0; in_r = 16'h0F5A;
        push_wait();
        check("t1_ready_full", in_ready, 1'b0);
        enable = 1'b1;
        tick();
        check("t1_entry", {28'd0, in_ready, i2s_bclk, i2s_ws, i2s_data}, 32'h9);
        capture_frame(rl, rr, wsok, ta, tb);
        check("t1_frame", {rl, rr}, 32'hA5F0_0F5A);
        check("t1_ws", wsok, 1'b1);
        check("t1_bclk_period", tb - ta, 8);
        wait_rise();
        tc = cyc;
        check("t1_frame_len", tc - ta, 256);
        check("t1_underrun_next", under_pulses - p0, 1);
        enable = 1'b0;
        tick();

        // Empty frames: underrun pulse and counter.
        RESET = 1'b1; tick(); tick();
        RESET = 1'b0; tick();
        check("t2_ready", in_ready, 1'b1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("t2_cnt0", underrun_cnt, 16'd0);
`endif
        p0 = under_pulses;
        enable = 1'b1;
        tick();
        check("t2_underrun_hi", underrun, 1'b1);
        tick();
        check("t2_underrun_lo", underrun, 1'b0);
        capture_frame(rl, rr, wsok, ta, tb);
        check("t2_frame", {rl, rr}, 32'd0);
        check("t2_pulses1", under_pulses - p0, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("t2_cnt1", underrun_cnt, 16'd1);
`endif
        wait_rise();
        check("t2_pulses2", under_pulses - p0, 2);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("t2_cnt2", underrun_cnt, 16'd2);
`endif
        enable = 1'b0;
        tick();

        // Streaming: pairs (1,2),(3,4),... over 8 frames.
        p0 = under_pulses;
        fork
            begin
                for (int p = 0; p < 9; p++) begin
                    in_l = 16'(2 * p + 1);
                    in_r = 16'(2 * p + 2);
                    push_wait();
                end
            end
            begin
                for (int n = 0; n < 50 && in_ready !== 1'b0; n++) tick();
                check("t3_ready_full", in_ready, 1'b0);
                enable = 1'b1;
                tick();
                for (int f = 0; f < 8; f++) begin
                    capture_frame(rl, rr, wsok, ta, tb);
                    check("t3_frame", {rl, rr}, {16'(2 * f + 1), 16'(2 * f + 2)});
                end
                enable = 1'b0;
            end
        join
        check("t3_no_underrun", under_pulses - p0, 0);
        tick();

        // Stop at slot 10, then restart with the held pair.
        enable = 1'b1;
        tick();
        in_l = 16'h9234; in_r = 16'hABCD;
        push_wait();
        for (int k = 0; k < 11; k++) wait_rise();
        enable = 1'b0;
        tick();
        check("t4_stop_idle", {29'd0, i2s_bclk, i2s_ws, i2s_data}, 32'd0);
        enable = 1'b1;
        tick();
        check("t4_restart_msb", {30'd0, i2s_ws, i2s_data}, 32'd1);
        capture_frame(rl, rr, wsok, ta, tb);
        check("t4_frame", {rl, rr}, 32'h9234_ABCD);
        enable = 1'b0;
        tick();

        // RESET at slot 20 with the holding register full.
        in_l = 16'h5555; in_r = 16'h6666;
        push_wait();
        enable = 1'b1;
        tick();
        in_l = 16'h7777; in_r = 16'h1111;
        push_wait();
        for (int k = 0; k < 21; k++) wait_rise();
        check("t5_pre_full", {30'd0, i2s_ws, in_ready}, 32'd2);
        RESET = 1'b1;
        tick();
        check("t5_rst_outputs", {27'd0, i2s_bclk, i2s_ws, i2s_data, underrun, in_ready}, 32'd0);
        tick();
        RESET = 1'b0;
        p0 = under_pulses;
        tick();
        check("t5_ready_underrun", {30'd0, in_ready, underrun}, 32'd3);
        capture_frame(rl, rr, wsok, ta, tb);
        check("t5_frame", {rl, rr}, 32'd0);
        check("t5_pulses", under_pulses - p0, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("t5_cnt", underrun_cnt, 16'd1);
`endif
        enable = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: BCLK half-period in clk_sys cycles; legal range 2..255.
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic in this domain.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  run/stop serializer.
REQ-005 SHALL have port in_l  input  16  left sample, signed two's complement.
REQ-006 SHALL have port in_r  input  16  right sample, signed two's complement.
REQ-007 SHALL have port in_valid  input  1  sample pair offered.
REQ-008 SHALL have port in_ready  output  1  holding register empty.
REQ-009 SHALL have port i2s_bclk  output  1  bit clock.
REQ-010 SHALL have port i2s_ws  output  1  word select; 0 = left, 1 = right.
REQ-011 SHALL have port i2s_data  output  1  serial data, MSB first.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-013 SHALL have a one-entry holding register {L,R,full}; in_ready = ~full; transfer when in_valid & in_ready sets full and captures in_l/in_r.
REQ-014 SHALL have states IDLE and RUN; IDLE->RUN when enable=1; any state->IDLE when enable=0, taking effect the next cycle.
REQ-015 In IDLE: i2s_bclk=0, i2s_ws=0, i2s_data=0, divider=0, slot=0; holding register retained and still accepts input.
REQ-016 On the IDLE->RUN edge: load a frame per REQ-020; slot=0; i2s_bclk=0.
REQ-017 In RUN: divider counts 0..CLK_DIV-1; on wrap i2s_bclk toggles; BCLK period = 2*CLK_DIV cycles; duty 50%.
REQ-018 On the cycle i2s_bclk goes 1->0 (falling edge), slot advances mod 32, and i2s_ws/i2s_data update on that same clock edge; they are stable across the following rising edge.
REQ-019 Slot s output: data = L[15-s] for s=0..15, R[31-s] for s=16..31; ws = 1 for s=15..30, else 0 (WS leads MSB by one BCLK, standard I2S).
REQ-020 Frame load at RUN entry and at every falling edge taking slot 31->0: if full, copy L/R to the shift register and clear full; else load 0x0000/0x0000 and pulse underrun.
REQ-021 in_ready rises the cycle after a frame load consumes the holding register; a transfer can never coincide with a consume.
REQ-022 enable=0 mid-frame: the partial frame is discarded, and outputs reach IDLE values next cycle; a restart begins a fresh frame at slot 0.
REQ-023 Back-to-back frames: no idle BCLK between slot 31 and slot 0; throughput is one pair per 64*CLK_DIV cycles.

Reset
REQ-024 While RESET=1: state=IDLE, i2s_bclk=0, i2s_ws=0, i2s_data=0, underrun=0, full=0, in_ready=0, shift register=0, underrun_cnt=0.
REQ-025 in_ready=1 on the first cycle after RESET falls; RESET mid-frame aborts the frame and discards the holding register.

Configuration
REQ-026 Macro I2S_TX_UNDERRUN_CNT_EN, when defined, SHALL add output underrun_cnt (16 bits): it increments on each underrun pulse, saturates at 0xFFFF, and clears only on RESET.
REQ-027 Without I2S_TX_UNDERRUN_CNT_EN, the port SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 CLK_DIV=4, reset, enable=1, push L=0xA5F0 R=0x0F5A before the first frame -> a bench I2S receiver (latching on rising BCLK, word on WS change) decodes L=0xA5F0, R=0x0F5A; BCLK period is 8 cycles; the frame is 256 cycles.
REQ-029 Enable with no input -> first frame all zeros, underrun high for exactly 1 cycle, underrun_cnt=1 (macro defined); a second empty frame gives underrun_cnt=2.
REQ-030 Hold in_valid=1 with an incrementing pattern 0x0001.. -> in_ready low while full; each frame outputs consecutive pairs with no loss or duplication over 8 frames.
REQ-031 Deassert enable at slot 10 -> next cycle bclk=ws=data=0; re-enable -> the data from the holding register appears from slot 0, MSB first.
REQ-032 Assert RESET at slot 20 with full=1 -> all outputs at reset values; after release in_ready=1 and the next frame underruns (zeros).
